// File: rtl/program_loader_pkg.sv
// program_loader_pkg
// Shared definitions for the boot-time program loader: the FSM state
// encoding, image framing constants and the byte-accepting state decode.
package program_loader_pkg;

  typedef enum logic [3:0] {
    IDLE,
    HDR0,
    HDR1,
    B0,
    B1,
    B2,
    CHK,
    RELEASE,
    INIT,
    DONE,
    ERROR
  } state_t;

  // Bytes per instruction word and per header (little-endian word count).
  localparam int unsigned INSTR_BYTES = 3;
  localparam int unsigned HDR_BYTES   = 2;

  // States in which the loader takes a stream byte every cycle it is offered.
  function automatic logic accepts_byte(input state_t s);
    return s inside {HDR0, HDR1, B0, B1, B2, CHK};
  endfunction

endpackage

// File: rtl/program_loader_word_assembler.sv
// loader_word_assembler
// Collects the three bytes of one instruction word, checks that the unused
// high bits of the last byte are zero, and issues a registered one-cycle
// instruction-memory write the cycle after the last byte is accepted.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   i_data          stream byte
//   i_take_b0/1/2   byte i_data is accepted as b0 / b1 / b2 this cycle
//   i_addr          word index to write at
//   o_fmt_ok        i_data is a legal b2 (bits above the word width are zero)
//   o_we/o_addr/o_wdata  registered memory write port
module loader_word_assembler
  import program_loader_pkg::*;
#(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned INSTR_W = 19
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         i_data,
  input  logic               i_take_b0,
  input  logic               i_take_b1,
  input  logic               i_take_b2,
  input  logic [ADDR_W-1:0]  i_addr,
  output logic               o_fmt_ok,
  output logic               o_we,
  output logic [ADDR_W-1:0]  o_addr,
  output logic [INSTR_W-1:0] o_wdata
);

  // Number of meaningful bits carried by the last byte of a word.
  localparam int unsigned B2_BITS = INSTR_W - 8 * (INSTR_BYTES - 1);

  logic [7:0]         r_b0;
  logic [7:0]         r_b1;
  logic               r_we;
  logic [ADDR_W-1:0]  r_addr;
  logic [INSTR_W-1:0] r_wdata;
  logic               w_fmt_ok;

  assign w_fmt_ok = (i_data[7:B2_BITS] == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_b0    <= '0;
      r_b1    <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= 1'b0;
      if (i_take_b0) r_b0 <= i_data;
      if (i_take_b1) r_b1 <= i_data;
      if (i_take_b2 && w_fmt_ok) begin
        r_we    <= 1'b1;
        r_addr  <= i_addr;
        r_wdata <= {i_data[B2_BITS-1:0], r_b1, r_b0};
      end
    end
  end

  assign o_fmt_ok = w_fmt_ok;
  assign o_we     = r_we;
  assign o_addr   = r_addr;
  assign o_wdata  = r_wdata;

endmodule

// File: rtl/program_loader.sv
// program_loader
// Boot-time loader in front of the core. Receives a program image as a byte
// stream (count_lo, count_hi, N x {b0,b1,b2}, xor checksum), writes each
// 19-bit word to instruction memory, then releases the core from reset and
// pulses init. Malformed images leave the core held and raise err.
// Ports:
//   clk, rst               clock, synchronous active-low reset
//   start                  begin a load (honoured in IDLE, DONE, ERROR)
//   s_data/s_valid/s_ready byte stream handshake
//   im_we/im_addr/im_wdata instruction-memory write port
//   core_rst, core_init    core hold-in-reset and one-cycle init pulse
//   busy, done, err        load status (err sticky until next start)
//   words_loaded           number of words written by the current load
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned INSTR_W = 19
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [7:0]         s_data,
  input  logic               s_valid,
  output logic               s_ready,
  output logic               im_we,
  output logic [ADDR_W-1:0]  im_addr,
  output logic [INSTR_W-1:0] im_wdata,
  output logic               core_rst,
  output logic               core_init,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [ADDR_W:0]    words_loaded
);

  localparam int unsigned N_W = 8 * HDR_BYTES;

  state_t           r_state;
  logic [7:0]       r_lo;
  logic [N_W-1:0]   r_count;
  logic [7:0]       r_chk;
  logic [ADDR_W:0]  r_index;
  logic [ADDR_W:0]  r_words;
  logic             r_core_rst;
  logic             r_core_init;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  logic             w_ready;
  logic             w_xfer;
  logic [N_W-1:0]   w_n;
  logic             w_n_too_big;
  logic             w_more;
  logic             w_fmt_ok;

  assign w_ready     = accepts_byte(r_state);
  assign w_xfer      = s_valid && w_ready;
  assign w_n         = {s_data, r_lo};
  assign w_n_too_big = 32'(w_n) > (32'd1 << ADDR_W);
  assign w_more      = (32'(r_index) + 32'd1) < 32'(r_count);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_lo        <= '0;
      r_count     <= '0;
      r_chk       <= '0;
      r_index     <= '0;
      r_words     <= '0;
      r_core_rst  <= 1'b1;
      r_core_init <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_core_init <= 1'b0;
      // The checksum covers every byte before the checksum byte itself.
      if (w_xfer && r_state != CHK) r_chk <= r_chk ^ s_data;
      case (r_state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            r_state    <= HDR0;
            r_busy     <= 1'b1;
            r_core_rst <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_chk      <= '0;
            r_index    <= '0;
            r_words    <= '0;
          end
        end
        HDR0: begin
          if (w_xfer) begin
            r_lo    <= s_data;
            r_state <= HDR1;
          end
        end
        HDR1: begin
          if (w_xfer) begin
            r_count <= w_n;
            if (w_n_too_big) begin
              r_state <= ERROR;
              r_busy  <= 1'b0;
              r_err   <= 1'b1;
            end else if (w_n == '0) begin
              r_state <= CHK;
            end else begin
              r_state <= B0;
            end
          end
        end
        B0: if (w_xfer) r_state <= B1;
        B1: if (w_xfer) r_state <= B2;
        B2: begin
          if (w_xfer) begin
            if (!w_fmt_ok) begin
              r_state <= ERROR;
              r_busy  <= 1'b0;
              r_err   <= 1'b1;
            end else begin
              // The assembler captures the pre-increment index for im_addr.
              r_index <= r_index + (ADDR_W + 1)'(1);
              r_words <= r_words + (ADDR_W + 1)'(1);
              r_state <= w_more ? B0 : CHK;
            end
          end
        end
        CHK: begin
          if (w_xfer) begin
            if (s_data == r_chk) begin
              r_state    <= RELEASE;
              r_core_rst <= 1'b0;
            end else begin
              r_state <= ERROR;
              r_busy  <= 1'b0;
              r_err   <= 1'b1;
            end
          end
        end
        RELEASE: begin
          r_state     <= INIT;
          r_core_init <= 1'b1;
        end
        INIT: begin
          r_state <= DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  loader_word_assembler #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_asm (
    .clk       (clk),
    .rst       (rst),
    .i_data    (s_data),
    .i_take_b0 (w_xfer && r_state == B0),
    .i_take_b1 (w_xfer && r_state == B1),
    .i_take_b2 (w_xfer && r_state == B2),
    .i_addr    (r_index[ADDR_W-1:0]),
    .o_fmt_ok  (w_fmt_ok),
    .o_we      (im_we),
    .o_addr    (im_addr),
    .o_wdata   (im_wdata)
  );

  assign s_ready      = w_ready;
  assign core_rst     = r_core_rst;
  assign core_init    = r_core_init;
  assign busy         = r_busy;
  assign done         = r_done;
  assign err          = r_err;
  assign words_loaded = r_words;

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader
// Directed bench for program_loader. Instance A uses ADDR_W=12, instance B
// ADDR_W=4; they share the stream and reset but have separate start inputs,
// and sel picks which one the monitors and byte driver follow.
`timescale 1ns/1ps
module tb_program_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_a, start_b;
  logic [7:0] s_data;
  logic       s_valid;
  logic       sel;

  logic        rdy_a, we_a, crst_a, cinit_a, busy_a, done_a, err_a;
  logic [11:0] addr_a;
  logic [18:0] wd_a;
  logic [12:0] wl_a;

  logic        rdy_b, we_b, crst_b, cinit_b, busy_b, done_b, err_b;
  logic [3:0]  addr_b;
  logic [18:0] wd_b;
  logic [4:0]  wl_b;

  program_loader #(.ADDR_W(12), .INSTR_W(19)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .s_data(s_data), .s_valid(s_valid),
    .s_ready(rdy_a), .im_we(we_a), .im_addr(addr_a), .im_wdata(wd_a),
    .core_rst(crst_a), .core_init(cinit_a), .busy(busy_a), .done(done_a),
    .err(err_a), .words_loaded(wl_a)
  );

  program_loader #(.ADDR_W(4), .INSTR_W(19)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .s_data(s_data), .s_valid(s_valid),
    .s_ready(rdy_b), .im_we(we_b), .im_addr(addr_b), .im_wdata(wd_b),
    .core_rst(crst_b), .core_init(cinit_b), .busy(busy_b), .done(done_b),
    .err(err_b), .words_loaded(wl_b)
  );

  logic        m_rdy, m_we, m_crst, m_cinit, m_busy, m_done, m_err;
  logic [31:0] m_addr, m_wd, m_wl;
  assign m_rdy   = sel ? rdy_b   : rdy_a;
  assign m_we    = sel ? we_b    : we_a;
  assign m_crst  = sel ? crst_b  : crst_a;
  assign m_cinit = sel ? cinit_b : cinit_a;
  assign m_busy  = sel ? busy_b  : busy_a;
  assign m_done  = sel ? done_b  : done_a;
  assign m_err   = sel ? err_b   : err_a;
  assign m_addr  = sel ? 32'(addr_b) : 32'(addr_a);
  assign m_wd    = sel ? 32'(wd_b)   : 32'(wd_a);
  assign m_wl    = sel ? 32'(wl_b)   : 32'(wl_a);

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitors: memory writes, init pulses and release timing of the selected DUT.
  int          cyc = 0;
  logic [31:0] wr_addr[$], wr_data[$];
  logic [31:0] exp_a[$], exp_d[$];
  int          n_init, n_overlap, rel_cyc, init_cyc, last_we_cyc;
  logic        prev_crst;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (m_we) begin
      wr_addr.push_back(m_addr);
      wr_data.push_back(m_wd);
      last_we_cyc = cyc;
    end
    if (m_cinit) begin
      n_init++;
      init_cyc = cyc;
      if (m_crst) n_overlap++;
    end
    if (prev_crst && !m_crst) rel_cyc = cyc;
    prev_crst = m_crst;
  end

  task automatic clr_mon();
    wr_addr.delete(); wr_data.delete();
    exp_a.delete();   exp_d.delete();
    n_init = 0; n_overlap = 0;
    rel_cyc = -100; init_cyc = -1000; last_we_cyc = -1000;
    prev_crst = m_crst;
  endtask

  task automatic pulse_start();
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit gap);
    int g = 0;
    s_data  = b;
    s_valid = 1'b1;
    while (!m_rdy && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (g >= 20) check("ready_timeout", 32'(m_rdy), 1);
    @(negedge clk);
    s_valid = 1'b0;
    if (gap) @(negedge clk);
  endtask

  task automatic send_img(input logic [7:0] img[$], input bit gap);
    foreach (img[i]) send(img[i], gap);
  endtask

  task automatic wait_end();
    int g = 0;
    while (!(m_done || m_err) && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("end_timeout", 32'(g < 50), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_writes(input string t);
    check({t, "_wr_count"}, wr_addr.size(), exp_a.size());
    foreach (exp_a[i]) begin
      if (i < wr_addr.size()) begin
        check({t, "_wr_addr"}, wr_addr[i], exp_a[i]);
        check({t, "_wr_data"}, wr_data[i], exp_d[i]);
      end
    end
  endtask

  task automatic check_final(input string t, input logic e_done, input logic e_err,
                             input logic e_crst, input logic [31:0] e_words, input int e_init);
    check({t, "_done"},     32'(m_done), 32'(e_done));
    check({t, "_err"},      32'(m_err),  32'(e_err));
    check({t, "_core_rst"}, 32'(m_crst), 32'(e_crst));
    check({t, "_busy"},     32'(m_busy), 0);
    check({t, "_words"},    m_wl, e_words);
    check({t, "_n_init"},   n_init, e_init);
    check({t, "_overlap"},  n_overlap, 0);
  endtask

  task automatic expect_img1();
    exp_a.push_back(32'd0); exp_d.push_back(32'h12345);
    exp_a.push_back(32'd1); exp_d.push_back(32'h7FFFF);
  endtask

  logic [7:0] img1[$], img[$];
  logic [7:0] b0, b1, b2, x;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; start_a = 1'b0; start_b = 1'b0;
    s_data = '0; s_valid = 1'b0; sel = 1'b0;
    clr_mon();
    img1 = '{8'h02, 8'h00, 8'h45, 8'h23, 8'h01, 8'hFF, 8'hFF, 8'h07, 8'h62};
    repeat (3) @(negedge clk);

    // Reset state of both instances
    check("rst_core_rst_a", 32'(crst_a), 1);
    check("rst_busy_a",     32'(busy_a), 0);
    check("rst_done_a",     32'(done_a), 0);
    check("rst_err_a",      32'(err_a),  0);
    check("rst_ready_a",    32'(rdy_a),  0);
    check("rst_we_a",       32'(we_a),   0);
    check("rst_init_a",     32'(cinit_a), 0);
    check("rst_words_a",    32'(wl_a),   0);
    check("rst_core_rst_b", 32'(crst_b), 1);
    check("rst_words_b",    32'(wl_b),   0);
    rst = 1'b1;
    @(negedge clk);

    // 1: two-word image, continuous stream
    clr_mon(); expect_img1();
    pulse_start();
    check("t1_busy_after_start", 32'(m_busy), 1);
    send_img(img1, 1'b0);
    wait_end();
    check_writes("t1");
    check_final("t1", 1'b1, 1'b0, 1'b0, 2, 1);
    check("t1_init_after_release", init_cyc - rel_cyc, 1);
    check("t1_init_gap_ge2", 32'(init_cyc - last_we_cyc >= 2), 1);

    // 2: restart from DONE, s_valid toggling every other cycle
    clr_mon(); expect_img1();
    pulse_start();
    check("t2_restart_done",  32'(m_done), 0);
    check("t2_restart_crst",  32'(m_crst), 1);
    check("t2_restart_words", m_wl, 0);
    check("t2_restart_busy",  32'(m_busy), 1);
    send_img(img1, 1'b1);
    wait_end();
    check_writes("t2");
    check_final("t2", 1'b1, 1'b0, 1'b0, 2, 1);
    check("t2_init_after_release", init_cyc - rel_cyc, 1);

    // 3: corrupt checksum
    clr_mon(); expect_img1();
    img = img1;
    img[8] = 8'h63;
    pulse_start();
    send_img(img, 1'b0);
    wait_end();
    check_writes("t3");
    check_final("t3", 1'b0, 1'b1, 1'b1, 2, 0);

    // 4: restart from ERROR; b2 with a high bit set is rejected at once
    clr_mon();
    pulse_start();
    check("t4_restart_err",  32'(m_err), 0);
    check("t4_restart_busy", 32'(m_busy), 1);
    img = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h08};
    send_img(img, 1'b0);
    check("t4_err_immediate", 32'(m_err), 1);
    check("t4_ready_low",     32'(m_rdy), 0);
    repeat (3) @(negedge clk);
    check_writes("t4");
    check_final("t4", 1'b0, 1'b1, 1'b1, 0, 0);

    // 5: empty image
    clr_mon();
    pulse_start();
    img = '{8'h00, 8'h00, 8'h00};
    send_img(img, 1'b0);
    wait_end();
    check_writes("t5");
    check_final("t5", 1'b1, 1'b0, 1'b0, 0, 1);

    // 6: ADDR_W=4, N=17 exceeds memory
    sel = 1'b1;
    @(negedge clk);
    clr_mon();
    pulse_start();
    img = '{8'h11, 8'h00};
    send_img(img, 1'b0);
    check("t6_err_after_hdr", 32'(m_err), 1);
    check("t6_ready_low",     32'(m_rdy), 0);
    repeat (3) @(negedge clk);
    check_writes("t6");
    check_final("t6", 1'b0, 1'b1, 1'b1, 0, 0);

    // 7: ADDR_W=4, N=16 fills addresses 0..15
    clr_mon();
    img = '{8'h10, 8'h00};
    x = 8'h10;
    for (int i = 0; i < 16; i++) begin
      b0 = 8'(i * 17);
      b1 = 8'hA0 + 8'(i);
      b2 = 8'(i % 8);
      img.push_back(b0); img.push_back(b1); img.push_back(b2);
      x = x ^ b0 ^ b1 ^ b2;
      exp_a.push_back(32'(i));
      exp_d.push_back({13'b0, b2[2:0], b1, b0});
    end
    img.push_back(x);
    pulse_start();
    send_img(img, 1'b0);
    wait_end();
    check_writes("t7");
    check_final("t7", 1'b1, 1'b0, 1'b0, 16, 1);

    // 8: reset in the middle of a word, then a clean reload
    sel = 1'b0;
    @(negedge clk);
    clr_mon();
    pulse_start();
    img = '{8'h02, 8'h00, 8'h45, 8'h23};
    send_img(img, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("t8_rst_core_rst", 32'(m_crst), 1);
    check("t8_rst_ready",    32'(m_rdy),  0);
    check("t8_rst_busy",     32'(m_busy), 0);
    check("t8_rst_done",     32'(m_done), 0);
    check("t8_rst_words",    m_wl, 0);
    rst = 1'b1;
    @(negedge clk);
    check("t8_no_partial_write", wr_addr.size(), 0);
    clr_mon(); expect_img1();
    pulse_start();
    send_img(img1, 1'b0);
    wait_end();
    check_writes("t8");
    check_final("t8", 1'b1, 1'b0, 1'b0, 2, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
